mac_tx_arbiter: RTL
===================

Name: mac_tx_arbiter

Overview:
Frame-level round-robin arbiter that lets several 8-bit AXI-stream frame sources (ARP, UDP/IP, ICMP, …) share the single MAC transmit stream feeding mac_tx_crc_calculate. A grant is locked for a whole frame, from first beat to tlast, so frames never interleave. Frames longer than MAX_FRAME are cut at MAX_FRAME bytes and the rest of that source frame is drained and discarded. Sits between the protocol encoders and the mac_tdata_in/mac_tvalid_in/mac_tready_out/mac_tlast_in port of the CRC/preamble block.

Parameters:
PORTS, 3, number of requesting sources (2..8)
MAX_FRAME, 1514, max bytes forwarded per frame (eth head + payload, CRC excluded); 11-bit counter

Ports:
logic_clk  input  1  single clock for the whole block
logic_rst  input  1  synchronous reset, active-high
s_tdata_in  input  8*PORTS  source data; port i occupies bits [8*i+7:8*i]
s_tvalid_in  input  PORTS  per-source valid
s_tready_out  output  PORTS  per-source ready
s_tlast_in  input  PORTS  per-source last beat
mac_tdata_out  output  8  data to the MAC tx stream
mac_tvalid_out  output  1  valid to the MAC tx stream
mac_tready_in  input  1  ready from the MAC tx stream
mac_tlast_out  output  1  last beat to the MAC tx stream
grant_out  output  PORTS  one-hot current grant; 0 when idle
trunc_pulse_out  output  1  one-cycle pulse on a truncation event

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state=IDLE, grant_out=0, last_grant=PORTS-1 (so port 0 wins first), byte_cnt=0.
  - s_tready_out=0, mac_tvalid_out=0, mac_tlast_out=0, mac_tdata_out=0, trunc_pulse_out=0.
  - Reset mid-frame abandons the frame. No tlast is emitted; downstream is reset by the same logic_rst.
- States: IDLE, PASS, DROP.
- IDLE:
  - All readys 0, mac_tvalid_out=0.
  - If any s_tvalid_in is high, pick the first requester scanning last_grant+1, last_grant+2, … modulo PORTS.
  - Register the one-hot grant, set byte_cnt=0, go to PASS.
  - Arbitration latency is 1 cycle. At least 1 IDLE cycle separates consecutive frames.
- PASS, with g = granted index:
  - Combinational forwarding: mac_tdata_out=s_tdata_in[g], mac_tvalid_out=s_tvalid_in[g], mac_tlast_out=s_tlast_in[g] | cut.
  - s_tready_out[g]=mac_tready_in; all other readys 0.
  - Zero added latency; no buffering.
  - A beat transfers when mac_tvalid_out & mac_tready_in. byte_cnt increments per transfer and saturates.
  - cut = (byte_cnt == MAX_FRAME-1).
  - Transfer with s_tlast_in[g]: last_grant<=g, grant_out<=0, go to IDLE. This applies even if cut is also true; no truncation pulse in that case.
  - Transfer with cut and no source tlast: mac_tlast_out is forced 1 on that beat, trunc_pulse_out=1 next cycle, go to DROP.
  - Source deasserting tvalid mid-frame just stalls the output. Grant is held indefinitely; no timeout.
  - Requests from other ports during PASS are ignored until return to IDLE.
- DROP:
  - mac_tvalid_out=0, mac_tlast_out=0.
  - s_tready_out[g]=1 (drain at full rate, independent of mac_tready_in); all other readys 0.
  - On s_tvalid_in[g] & s_tlast_in[g]: last_grant<=g, grant_out<=0, go to IDLE.
- Output data when not valid: mac_tdata_out is 0 in IDLE/DROP, and the selected source's data in PASS.
- Simultaneous requests in IDLE: strict rotation; the just-served port has lowest priority next round.
- Single-beat frame (tvalid+tlast on first beat) is legal: 1 transfer, then back to IDLE.

Test Plan:
- Single source: port 1 sends a 60-byte frame 0x00..0x3B with mac_tready_in=1 -> grant_out=3'b010 after 1 cycle; 60 consecutive output beats equal to input; mac_tlast_out only on 0x3B; IDLE cycle; grant_out=0.
- Fairness: ports 0,1,2 all hold 10-byte frames continuously -> output frame order 0,1,2,0,1,2; each frame contiguous; exactly 1 idle cycle between frames.
- Backpressure: port 0 sends 20-byte frame, mac_tready_in toggles 1/0 each cycle -> 20 beats delivered in order, none duplicated or lost; s_tready_out[0] mirrors mac_tready_in; ports 1-2 ready stays 0.
- Truncation: MAX_FRAME=16, port 2 sends 40 bytes -> 16 bytes output, mac_tlast_out on byte 16, trunc_pulse_out high 1 cycle; remaining 24 bytes drained with mac_tvalid_out=0; then IDLE.
- Boundary: MAX_FRAME=16, frame of exactly 16 bytes with source tlast on byte 16 -> normal end, no trunc pulse, no DROP.
- Reset mid-frame: assert logic_rst after 5 beats of port 1 -> next cycle all outputs 0, grant_out=0; with ports 1 and 2 then requesting, port 0 absent, port 1 is granted first (last_grant reset to PORTS-1, port 0 not requesting).

Source files
------------

// File: rtl/mac_tx_arbiter_if.sv
// Source-side and MAC-side AXI-stream bundle for the frame-level tx arbiter.
// The arbiter uses the slave view; the environment driving it uses master.
interface mac_tx_arbiter_if #(
   parameter int unsigned PORTS = 3
);
   logic [8*PORTS-1:0] s_tdata_in;
   logic [PORTS-1:0]   s_tvalid_in;
   logic [PORTS-1:0]   s_tready_out;
   logic [PORTS-1:0]   s_tlast_in;
   logic [7:0]         mac_tdata_out;
   logic               mac_tvalid_out;
   logic               mac_tready_in;
   logic               mac_tlast_out;
   logic [PORTS-1:0]   grant_out;
   logic               trunc_pulse_out;

   modport slave (
      input  s_tdata_in, s_tvalid_in, s_tlast_in, mac_tready_in,
      output s_tready_out, mac_tdata_out, mac_tvalid_out, mac_tlast_out,
      output grant_out, trunc_pulse_out
   );

   modport master (
      output s_tdata_in, s_tvalid_in, s_tlast_in, mac_tready_in,
      input  s_tready_out, mac_tdata_out, mac_tvalid_out, mac_tlast_out,
      input  grant_out, trunc_pulse_out
   );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Round-robin frame arbiter: locks a source for a whole frame, forwards it with
// zero latency, cuts frames at MAX_FRAME bytes and drains the remainder.
module mac_tx_arbiter #(
   parameter int unsigned PORTS     = 3,
   parameter int unsigned MAX_FRAME = 1514
) (
   input  logic            logic_clk,
   input  logic            logic_rst,
   mac_tx_arbiter_if.slave bus
);
   localparam int unsigned IW = $clog2(PORTS);
   localparam int unsigned CW = 11;
   localparam logic [CW-1:0] CUT_AT  = CW'(MAX_FRAME - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t           state, state_nxt;
   logic [PORTS-1:0] grant, grant_nxt;
   logic [IW-1:0]    gidx, gidx_nxt;
   logic [IW-1:0]    last_grant, last_grant_nxt;
   logic [CW-1:0]    byte_cnt, byte_cnt_nxt;
   logic             trunc, trunc_nxt;

   logic [7:0]       sel_data;
   logic             sel_valid;
   logic             sel_last;
   logic             cut;
   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic [IW-1:0]    cand;

   assign cut                 = (byte_cnt == CUT_AT);
   assign bus.grant_out       = grant;
   assign bus.trunc_pulse_out = trunc;

   // View of the currently granted source
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (gidx == IW'(i)) begin
            sel_data  = bus.s_tdata_in[8*i +: 8];
            sel_valid = bus.s_tvalid_in[i];
            sel_last  = bus.s_tlast_in[i];
         end
      end
   end

   // Rotating scan starting just after the previously served port
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_grant;
      cand       = last_grant;
      for (int unsigned k = 1; k <= PORTS; k++) begin
         cand = IW'((32'(last_grant) + k) % PORTS);
         if (!pick_found && bus.s_tvalid_in[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nxt          = state;
      grant_nxt          = grant;
      gidx_nxt           = gidx;
      last_grant_nxt     = last_grant;
      byte_cnt_nxt       = byte_cnt;
      trunc_nxt          = 1'b0;
      bus.s_tready_out   = '0;
      bus.mac_tdata_out  = '0;
      bus.mac_tvalid_out = 1'b0;
      bus.mac_tlast_out  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt    = PASS;
               gidx_nxt     = pick_idx;
               grant_nxt    = PORTS'(1) << pick_idx;
               byte_cnt_nxt = '0;
            end
         end
         PASS: begin
            bus.mac_tdata_out  = sel_data;
            bus.mac_tvalid_out = sel_valid;
            bus.mac_tlast_out  = sel_last | cut;
            bus.s_tready_out   = grant & {PORTS{bus.mac_tready_in}};
            if (sel_valid && bus.mac_tready_in) begin
               if (byte_cnt != CNT_MAX) byte_cnt_nxt = byte_cnt + CW'(1);
               // Source tlast wins over a coincident cut: normal end, no pulse
               if (sel_last) begin
                  state_nxt      = IDLE;
                  grant_nxt      = '0;
                  last_grant_nxt = gidx;
               end else if (cut) begin
                  state_nxt = DROP;
                  trunc_nxt = 1'b1;
               end
            end
         end
         DROP: begin
            bus.s_tready_out = grant;
            if (sel_valid && sel_last) begin
               state_nxt      = IDLE;
               grant_nxt      = '0;
               last_grant_nxt = gidx;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge logic_clk) begin
      if (logic_rst) begin
         state      <= IDLE;
         grant      <= '0;
         gidx       <= '0;
         last_grant <= IW'(PORTS - 1);
         byte_cnt   <= '0;
         trunc      <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         gidx       <= gidx_nxt;
         last_grant <= last_grant_nxt;
         byte_cnt   <= byte_cnt_nxt;
         trunc      <= trunc_nxt;
      end
   end
endmodule
